mux2_rr_arbiter: RTL and testbench



---
 rtl/mux2_rr_arbiter_pkg.sv | 20 ++
 rtl/mux2_rr_arbiter_if.sv | 29 ++
 rtl/mux2_rr_arbiter_mux2_w.sv | 14 +
 rtl/mux2_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 133 +++++++++++++
 5 files changed

// File: rtl/mux2_rr_arbiter_pkg.sv
// mux_arb_pkg: shared types and constants for the two-source round-robin
// arbiter.
//   arb_state_e      : IDLE, or which source currently owns the channel
//   SRC_A / SRC_B    : source encoding used on sel / out_src
//   DEF_WIDTH        : default beat width
//   DEF_MAX_BURST    : default burst limit
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  localparam logic SRC_A         = 1'b0;
  localparam logic SRC_B         = 1'b1;
  localparam int   DEF_WIDTH     = 4;
  localparam int   DEF_MAX_BURST = 4;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// mux2_rr_arbiter_if: the two source channels, the mux select and the
// registered output channel.
//   slave  : arbiter side (takes valids/data/out_ready, drives the rest)
//   master : environment side (sources and downstream sink)
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, sel, out_valid, out_data, out_src
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, sel, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux2_rr_arbiter_mux2_w.sv
// mux2_w: WIDTH-bit 2:1 combinational mux.
//   sel : 0 selects a, 1 selects b
//   a,b : data inputs
//   y   : selected data
module mux2_w #(
  parameter int WIDTH = 4
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: registered round-robin arbiter sharing one output channel
// between sources A and B, with a burst limit per owner.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mux2_rr_arbiter_if (a_*/b_* sources, sel,
//                out_* registered output channel)
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             rst_n,
  mux2_rr_arbiter_if.slave bus
);
  localparam int             CW   = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  MAXC = CW'(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             sel_q;
  logic             ov_q;
  logic [WIDTH-1:0] od_q;
  logic             os_q;

  logic             can_accept, gnt_vld, gnt, same;
  logic [WIDTH-1:0] mux_y;

  assign can_accept = !ov_q | bus.out_ready;

  // Grant: IDLE uses last_owner to break ties; an owner keeps the channel
  // until it runs dry or hits MAX_BURST while the other side waits.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = SRC_A;
    unique case (state_q)
      IDLE: begin
        if (bus.a_valid && bus.b_valid) begin gnt_vld = 1'b1; gnt = !last_q; end
        else if (bus.a_valid)           begin gnt_vld = 1'b1; gnt = SRC_A;  end
        else if (bus.b_valid)           begin gnt_vld = 1'b1; gnt = SRC_B;  end
      end
      OWN_A: begin
        if (bus.b_valid && (!bus.a_valid || cnt_q >= MAXC)) begin gnt_vld = 1'b1; gnt = SRC_B; end
        else if (bus.a_valid)                               begin gnt_vld = 1'b1; gnt = SRC_A; end
      end
      OWN_B: begin
        if (bus.a_valid && (!bus.b_valid || cnt_q >= MAXC)) begin gnt_vld = 1'b1; gnt = SRC_A; end
        else if (bus.b_valid)                               begin gnt_vld = 1'b1; gnt = SRC_B; end
      end
      default: ;
    endcase
  end

  // Outputs are gated by rst_n so they read as reset values while reset is
  // held, not only after the next edge.
  assign bus.a_ready   = rst_n & can_accept & gnt_vld & (gnt == SRC_A);
  assign bus.b_ready   = rst_n & can_accept & gnt_vld & (gnt == SRC_B);
  assign bus.sel       = rst_n & (gnt_vld ? gnt : sel_q);
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_src   = os_q;

  mux2_w #(.WIDTH(WIDTH)) u_mux (
    .sel (gnt),
    .a   (bus.a_data),
    .b   (bus.b_data),
    .y   (mux_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    same    = ((state_q == OWN_A) && (gnt == SRC_A)) ||
              ((state_q == OWN_B) && (gnt == SRC_B));
    if (can_accept) begin
      if (gnt_vld) begin
        state_d = (gnt == SRC_B) ? OWN_B : OWN_A;
        last_d  = gnt;
        if (!same)              cnt_d = CW'(1);
        else if (cnt_q >= MAXC) cnt_d = MAXC;
        else                    cnt_d = cnt_q + CW'(1);
      end else begin
        // No grant with room to accept means both sources are idle.
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= SRC_B;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q  <= 1'b0;
      od_q  <= '0;
      os_q  <= SRC_A;
      sel_q <= 1'b0;
    end else begin
      if (gnt_vld) sel_q <= gnt;
      if (can_accept) begin
        ov_q <= gnt_vld;
        if (gnt_vld) begin
          od_q <= mux_y;
          os_q <= gnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;
  localparam int W  = 4;
  localparam int MB = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.WIDTH(W)) bus ();

  mux2_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: ownership, run length of the current owner, and the
  // contents of the output register.
  bit       m_ov, m_os, m_sel, m_has, m_owner, m_last;
  bit [W-1:0] m_od;
  int       m_run;

  task automatic cyc(input bit rn, input bit av, input bit [W-1:0] ad,
                     input bit bv, input bit [W-1:0] bd, input bit ordy);
    bit ca, has_g, g, xv, ov, e_sel, e_ar, e_br;
    @(negedge clk);
    rst_n = rn;
    bus.a_valid = av; bus.a_data = ad;
    bus.b_valid = bv; bus.b_data = bd;
    bus.out_ready = ordy;
    #1;
    if (!rn) begin
      m_ov = 0; m_od = '0; m_os = 0; m_sel = 0;
      m_has = 0; m_run = 0; m_last = 1;
    end
    ca = !m_ov || ordy;
    has_g = 0; g = 0;
    if (rn) begin
      if (!m_has) begin
        if (av && bv)      begin has_g = 1; g = !m_last; end
        else if (av || bv) begin has_g = 1; g = bv; end
      end else begin
        xv = m_owner ? bv : av;
        ov = m_owner ? av : bv;
        if (ov && (!xv || m_run >= MB)) begin has_g = 1; g = !m_owner; end
        else if (xv)                    begin has_g = 1; g = m_owner; end
      end
    end
    e_sel = rn && (has_g ? g : m_sel);
    e_ar  = rn && ca && has_g && !g;
    e_br  = rn && ca && has_g && g;
    chk("a_ready",   bus.a_ready,   e_ar);
    chk("b_ready",   bus.b_ready,   e_br);
    chk("sel",       bus.sel,       e_sel);
    chk("out_valid", bus.out_valid, m_ov);
    chk("out_src",   bus.out_src,   m_os);
    chk("out_data",  bus.out_data,  m_od);
    if (rn) begin
      m_sel = e_sel;
      if (ca) begin
        if (has_g) begin
          m_ov = 1; m_od = g ? bd : ad; m_os = g;
          m_run = (m_has && m_owner == g) ? ((m_run < MB) ? m_run + 1 : MB) : 1;
          m_has = 1; m_owner = g; m_last = g;
        end else begin
          m_ov = 0; m_has = 0; m_run = 0;
        end
      end
    end
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.a_valid = 0; bus.a_data = '0;
    bus.b_valid = 0; bus.b_data = '0;
    bus.out_ready = 0;

    // Reset with both sources streaming: A wins the first tie.
    cyc(0, 1, 4'h3, 1, 4'h5, 1);
    cyc(0, 1, 4'h3, 1, 4'h5, 1);
    cyc(1, 1, 4'h3, 1, 4'h5, 1);
    #1;
    chk("first_valid", bus.out_valid, 1'b1);
    chk("first_src",   bus.out_src,   1'b0);
    chk("first_data",  bus.out_data,  4'h3);

    // Both valid continuously: bursts of MB, no bubbles.
    for (int i = 0; i < 8; i++) cyc(1, 1, 4'(i), 1, 4'(i + 8), 1);

    // Only B: stays with B, A never ready.
    cyc(1, 0, 4'h0, 1, 4'hA, 1);
    cyc(1, 0, 4'h0, 1, 4'hB, 1);
    cyc(1, 0, 4'h0, 1, 4'hC, 1);
    cyc(1, 0, 4'h0, 1, 4'hD, 1);
    cyc(1, 0, 4'h0, 0, 4'h0, 1);
    cyc(1, 0, 4'h0, 0, 4'h0, 1);

    // Stall with 0x7 held for three cycles, then drain and refill together.
    cyc(1, 1, 4'h7, 0, 4'h0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 4'h9, 1, 4'h4, 0);
    #1;
    chk("stall_hold", bus.out_data, 4'h7);
    cyc(1, 1, 4'h9, 1, 4'h4, 1);

    // Owner A drops valid while B waits: B granted that cycle.
    cyc(1, 0, 4'h0, 1, 4'h6, 1);
    cyc(1, 0, 4'h0, 1, 4'h2, 1);

    // Reset while B's beat is held under stall.
    cyc(1, 0, 4'h0, 1, 4'h1, 0);
    cyc(0, 1, 4'h3, 1, 4'h5, 0);
    cyc(1, 1, 4'h3, 1, 4'h5, 1);
    cyc(1, 1, 4'h3, 1, 4'h5, 1);

    // Randomised traffic, including occasional resets.
    for (int i = 0; i < 500; i++)
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), 4'($urandom),
          ($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 3) != 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
